// File: rtl/snake_game_ctrl_pkg.sv
// Shared main-state codes for the snake game sequencer and the snake datapath.
package snake_game_ctrl_pkg;

  typedef enum logic [2:0] {
    MAIN_IDLE  = 3'd0,
    MAIN_START = 3'd1,
    MAIN_GAME1 = 3'd2,
    MAIN_GAME2 = 3'd3,
    MAIN_GAME3 = 3'd4,
    MAIN_WIN   = 3'd5,
    MAIN_LOSE  = 3'd6
  } main_state_e;

  localparam int unsigned TICK_W = 32;
  localparam int unsigned HOLD_W = 32;

  function automatic logic is_game(input main_state_e s);
    return (s == MAIN_GAME1) || (s == MAIN_GAME2) || (s == MAIN_GAME3);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement strobe generator: speed-scaled period counter with pause and accelerate.
module snake_tick_gen
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 32'd16777216,
  parameter int unsigned MAX_SPEED   = 32'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pause,
  input  logic       accelerate,
  input  logic       clear,
  output logic [2:0] speed,
  output logic       move_tick
);

  if (((BASE_PERIOD >> MAX_SPEED) < 2) || (MAX_SPEED > 7)) begin : g_bad_period
    $error("snake_tick_gen: BASE_PERIOD >> MAX_SPEED must be >= 2 and MAX_SPEED <= 7");
  end

  localparam logic [2:0] MAX_SPEED_C = 3'(MAX_SPEED);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [2:0]        speed_q, speed_d;
  logic              tick_q, tick_d;
  logic [TICK_W-1:0] period_m1;
  logic              at_wrap;

  assign period_m1 = (TICK_W'(BASE_PERIOD) >> speed_q) - TICK_W'(1);
  assign at_wrap   = !pause && (cnt_q == period_m1);

  // A wrap coinciding with an effective accelerate still fires; the counter
  // then restarts from zero under the new period.
  always_comb begin
    cnt_d   = cnt_q;
    speed_d = speed_q;
    tick_d  = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      speed_d = '0;
    end else if (enable) begin
      tick_d = at_wrap;
      if (accelerate && (speed_q < MAX_SPEED_C)) begin
        speed_d = speed_q + 3'd1;
        cnt_d   = '0;
      end else if (!pause) begin
        cnt_d = at_wrap ? '0 : cnt_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      speed_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      tick_q  <= tick_d;
    end
  end

  assign speed     = speed_q;
  assign move_tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Top-level snake game sequencer: main state FSM, level/WIN/LOSE resolution, end-screen hold.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 32'd16777216,
  parameter int unsigned MAX_SPEED   = 32'd7,
  parameter int unsigned LVL2_LEN    = 32'd10,
  parameter int unsigned LVL3_LEN    = 32'd15,
  parameter int unsigned WIN_LEN     = 32'd20,
  parameter int unsigned HOLD_CYCLES = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst_global_n,
  input  logic       start,
  input  logic       pause,
  input  logic       accelerate,
  input  logic       finish,
  input  logic       death,
  input  logic [4:0] snake_len,
  output logic [2:0] state,
  output logic       move_tick,
  output logic [2:0] speed,
  output logic       game_active
);

  localparam logic [4:0]        LVL2_LEN_C  = 5'(LVL2_LEN);
  localparam logic [4:0]        LVL3_LEN_C  = 5'(LVL3_LEN);
  localparam logic [4:0]        WIN_LEN_C   = 5'(WIN_LEN);
  localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(HOLD_CYCLES - 1);

  main_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tick_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_IDLE:  if (start)  state_d = MAIN_START;
      MAIN_START: if (finish) state_d = MAIN_GAME1;
      MAIN_GAME1, MAIN_GAME2, MAIN_GAME3: begin
        if (death)                                            state_d = MAIN_LOSE;
        else if ((state_q == MAIN_GAME3) && (snake_len >= WIN_LEN_C))  state_d = MAIN_WIN;
        else if ((state_q == MAIN_GAME1) && (snake_len >= LVL2_LEN_C)) state_d = MAIN_GAME2;
        else if ((state_q == MAIN_GAME2) && (snake_len >= LVL3_LEN_C)) state_d = MAIN_GAME3;
      end
      MAIN_WIN, MAIN_LOSE:
        if (!finish && (hold_q >= HOLD_LAST_C)) state_d = MAIN_IDLE;
      default: state_d = MAIN_IDLE;
    endcase
  end

  always_comb begin
    hold_d = '0;
    if (((state_q == MAIN_WIN) || (state_q == MAIN_LOSE)) && (state_d != MAIN_IDLE)) begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state_q <= MAIN_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Gating on the next state as well keeps the strobe off in the cycle that enters WIN/LOSE.
  assign tick_en = is_game(state_q) && is_game(state_d);

  snake_tick_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .MAX_SPEED   (MAX_SPEED)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_global_n),
    .enable     (tick_en),
    .pause      (pause),
    .accelerate (accelerate),
    .clear      (state_q == MAIN_START),
    .speed      (speed),
    .move_tick  (move_tick)
  );

  assign state       = state_q;
  assign game_active = is_game(state_q);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl with small period/hold overrides.
module tb_snake_game_ctrl;
  import snake_game_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_global_n;
  logic       start, pause, accelerate, finish, death;
  logic [4:0] snake_len;
  logic [2:0] state;
  logic       move_tick;
  logic [2:0] speed;
  logic       game_active;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;

  int exp_state[$];
  int exp_tick[$];

  snake_game_ctrl #(
    .BASE_PERIOD (64),
    .MAX_SPEED   (3),
    .LVL2_LEN    (10),
    .LVL3_LEN    (15),
    .WIN_LEN     (20),
    .HOLD_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_global_n (rst_global_n),
    .start        (start),
    .pause        (pause),
    .accelerate   (accelerate),
    .finish       (finish),
    .death        (death),
    .snake_len    (snake_len),
    .state        (state),
    .move_tick    (move_tick),
    .speed        (speed),
    .game_active  (game_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns at the negedge just before edge e, so inputs set now are sampled at edge e.
  task automatic goto_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic push_ticks(input int first, input int period, input int count);
    for (int i = 0; i < count; i++) exp_tick.push_back(first + i * period);
  endtask

  task automatic pulse_acc(input int e, input int exp_speed);
    goto_edge(e);
    accelerate = 1'b1;
    @(negedge clk);
    accelerate = 1'b0;
    check("speed_after_acc", int'(speed), exp_speed);
  endtask

  // Monitor: consumes one expectation per observed state change or tick.
  always @(negedge clk) begin
    if (mon_en) begin
      if (state !== prev_state) begin
        compared++;
        if (exp_state.size() == 0) begin
          mismatched++;
          $display("FAIL state_seq: got %0d with no change expected (cycle %0d)", state, cyc);
        end else begin
          int e;
          e = exp_state.pop_front();
          if (int'(state) !== e) begin
            mismatched++;
            $display("FAIL state_seq: got %0d expected %0d (cycle %0d)", state, e, cyc);
          end
        end
        prev_state = state;
      end
      if (move_tick === 1'b1) begin
        compared++;
        if (exp_tick.size() == 0) begin
          mismatched++;
          $display("FAIL tick_time: got tick at cycle %0d expected none", cyc);
        end else begin
          int t;
          t = exp_tick.pop_front();
          if (cyc !== t) begin
            mismatched++;
            $display("FAIL tick_time: got tick at cycle %0d expected cycle %0d", cyc, t);
          end
        end
      end
    end
  end

  initial begin
    int e, big_e, a1, a2, a3, l3, s, g, lo, g2;
    rst_global_n = 1'b0;
    start = 1'b0; pause = 1'b0; accelerate = 1'b0;
    finish = 1'b0; death = 1'b0; snake_len = 5'd9;
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_speed", int'(speed), 0);
    check("reset_tick", int'(move_tick), 0);
    check("reset_active", int'(game_active), 0);
    rst_global_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Start handshake, finish held low for 5 cycles
    e = cyc + 1;
    start = 1'b1;
    exp_state.push_back(1);
    @(negedge clk);
    start = 1'b0;
    goto_edge(e + 5);
    check("start_wait", int'(state), 1);
    finish = 1'b1;
    exp_state.push_back(2);
    big_e = e + 5;
    push_ticks(big_e + 64, 64, 2);
    goto_edge(big_e + 1);
    check("game1_active", int'(game_active), 1);

    // Accelerate ladder with saturation
    a1 = big_e + 150;
    push_ticks(a1 + 32, 32, 3);
    pulse_acc(a1, 1);
    a2 = a1 + 100;
    push_ticks(a2 + 16, 16, 6);
    pulse_acc(a2, 2);
    a3 = a2 + 100;
    push_ticks(a3 + 8, 8, 15);
    pulse_acc(a3, 3);
    pulse_acc(a3 + 100, 3);

    // Pause 50 cycles mid-period
    goto_edge(a3 + 124);
    pause = 1'b1;
    goto_edge(a3 + 174);
    pause = 1'b0;
    push_ticks(a3 + 178, 8, 5);

    // Level ramp to WIN; WIN entry coincides with a would-be tick
    goto_edge(a3 + 190);
    snake_len = 5'd10;
    exp_state.push_back(3);
    goto_edge(a3 + 200);
    snake_len = 5'd15;
    exp_state.push_back(4);
    l3 = a3 + 218;
    goto_edge(l3);
    snake_len = 5'd20;
    finish = 1'b0;
    exp_state.push_back(5);
    exp_state.push_back(0);
    goto_edge(l3 + 4);
    check("win_hold", int'(state), 5);
    @(negedge clk);
    check("win_exit", int'(state), 0);
    check("win_exit_tick", int'(move_tick), 0);

    // Death and WIN length together in GAME3
    goto_edge(l3 + 6);
    snake_len = 5'd0;
    goto_edge(l3 + 8);
    start = 1'b1;
    exp_state.push_back(1);
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    goto_edge(s + 3);
    finish = 1'b1;
    exp_state.push_back(2);
    g = s + 3;
    goto_edge(g + 1);
    check("speed_cleared", int'(speed), 0);
    goto_edge(g + 2);
    snake_len = 5'd10;
    exp_state.push_back(3);
    goto_edge(g + 4);
    snake_len = 5'd15;
    exp_state.push_back(4);
    goto_edge(g + 6);
    death = 1'b1;
    snake_len = 5'd20;
    exp_state.push_back(6);
    @(negedge clk);
    death = 1'b0;
    lo = g + 6;
    goto_edge(lo + 10);
    check("lose_finish_hold", int'(state), 6);
    finish = 1'b0;
    exp_state.push_back(0);
    goto_edge(lo + 11);
    check("lose_exit", int'(state), 0);
    snake_len = 5'd0;

    // Async reset mid-cycle in GAME2 while a tick is presented
    goto_edge(lo + 14);
    start = 1'b1;
    exp_state.push_back(1);
    @(negedge clk);
    start = 1'b0;
    g2 = cyc + 2;
    goto_edge(g2);
    finish = 1'b1;
    exp_state.push_back(2);
    goto_edge(g2 + 2);
    snake_len = 5'd10;
    exp_state.push_back(3);
    exp_tick.push_back(g2 + 36);
    pulse_acc(g2 + 4, 1);
    goto_edge(g2 + 37);
    #2;
    exp_state.push_back(0);
    rst_global_n = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_speed", int'(speed), 0);
    check("arst_tick", int'(move_tick), 0);
    check("arst_active", int'(game_active), 0);
    @(negedge clk);
    rst_global_n = 1'b1;

    // Illegal state code recovers to IDLE
    @(negedge clk);
    #2;
    force dut.state_q = main_state_e'(3'd7);
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    check("illegal_recover", int'(state), 0);
    check("illegal_active", int'(game_active), 0);

    repeat (2) @(negedge clk);
    check("state_queue_empty", exp_state.size(), 0);
    check("tick_queue_empty", exp_tick.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Top-level game sequencer for the snake datapath. It drives the 3-bit main `state` bus consumed by the snake register block and handshakes with that block's `finish`/`death` outputs. It generates a one-cycle `move_tick` that strobes snake movement, with the period set by a speed level. It also advances GAME1→GAME2→GAME3 as the snake grows, and resolves WIN/LOSE.

Parameters:
- BASE_PERIOD, 16777216 (2^24): clk cycles per move at speed 0.
- MAX_SPEED, 7: highest speed level; period = BASE_PERIOD >> speed.
- LVL2_LEN, 10: snake_len at which GAME1 advances to GAME2.
- LVL3_LEN, 15: snake_len at which GAME2 advances to GAME3.
- WIN_LEN, 20: snake_len in GAME3 that wins.
- HOLD_CYCLES, 50000000: minimum cycles spent in WIN/LOSE before returning to IDLE.

Ports:
- clk  in  1  system clock
- rst_global_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse (debounced upstream)
- pause  in  1  level; freezes the tick counter while high
- accelerate  in  1  one-cycle pulse; raise speed by 1
- finish  in  1  datapath init/ack flag
- death  in  1  datapath death flag
- snake_len  in  5  current length
- state  out  3  main state code
- move_tick  out  1  one-cycle movement strobe
- speed  out  3  current speed level
- game_active  out  1  high in GAME1/2/3

Behaviour:
- Reset (async, rst_global_n low): state=IDLE, move_tick=0, speed=0, tick counter=0, hold counter=0. Deassertion is synchronous to clk.
- State codes in def.v: IDLE=0, START=1, GAME1=2, GAME2=3, GAME3=4, WIN=5, LOSE=6. Codes 7 and other illegal values go to IDLE on the next cycle.
- IDLE: `start`→START. All other inputs are ignored.
- START: speed←0, counter←0. Remain in START until finish==1, then go to GAME1. A `start` pulse here is ignored.
- GAMEx transitions, in priority order:
  1. death==1 → LOSE.
  2. GAME3 and snake_len>=WIN_LEN → WIN.
  3. GAME1 and snake_len>=LVL2_LEN → GAME2.
  4. GAME2 and snake_len>=LVL3_LEN → GAME3.
  - Only one transition fires per cycle; no skipping levels within one cycle.
- Tick counter (32-bit), active only in GAMEx with pause==0:
  - Counts 0..P-1, where P = BASE_PERIOD >> speed.
  - At P-1: move_tick=1 for exactly one cycle and the counter wraps to 0.
  - When pause==1: counter holds and move_tick=0.
  - On entry to any GAMEx from START, counter=0. Level changes GAME1→2→3 do not reset the counter.
- move_tick is registered: it is high in the cycle after the counter equals P-1. move_tick is never high outside GAMEx, including in the cycle of a transition into WIN/LOSE.
- accelerate pulse in GAMEx:
  - If speed<MAX_SPEED: speed+1 and counter←0 in the same cycle.
  - If speed==MAX_SPEED: saturates, no counter reset.
  - accelerate is ignored outside GAMEx.
  - If accelerate coincides with the counter reaching P-1: the tick still fires, then the counter restarts at 0 under the new period.
- P is never 0: BASE_PERIOD>>MAX_SPEED must be >=2. This is checked by an elaboration-time assertion.
- WIN/LOSE: hold counter increments each cycle. Go to IDLE once finish==0 and hold counter>=HOLD_CYCLES-1. The hold counter clears on exit.
- game_active = (state is GAME1, GAME2 or GAME3), derived combinationally from the state register.
- Reset mid-game: immediate IDLE. The datapath sees IDLE and stays idle until the next START.

Decomposition:
- def.v holds the MAIN_* state codes (the existing shared header, extended with MAIN_IDLE=0).
- One sub-module, snake_tick_gen, is natural: counter, pause, speed, period shift and move_tick. Its interface is enable, pause, accelerate and clear inputs; speed and move_tick outputs.
- The FSM and hold counter stay in snake_game_ctrl.

Test Plan:
Common overrides: BASE_PERIOD=64, MAX_SPEED=3, HOLD_CYCLES=4.
1. Reset then start; hold finish=0 for 5 cycles, then raise finish → state 0→1, stays 1 for 5 cycles, then 2. First move_tick arrives 64 cycles after entry to GAME1, then every 64 cycles.
2. In GAME1, pulse accelerate 4 times, spaced 100 cycles apart → speed 1,2,3,3. Tick spacing 32, 16, 8, 8. The counter restarts at each effective pulse.
3. Ramp snake_len 9→10→15→20 → state 2→3→4→5. At WIN, drop finish → IDLE after 4 cycles. No move_tick at or after the WIN-entry cycle.
4. death=1 and snake_len=20 in the same GAME3 cycle → LOSE (6), not WIN.
5. pause=1 for 50 cycles mid-period → no tick while paused. The tick is delayed by exactly 50 cycles.
6. Assert rst_global_n low asynchronously, mid-cycle, in GAME2 → state=0, speed=0, move_tick=0 immediately. Force state to 7 via backdoor → IDLE on the next clk.
